seq_player: RTL and testbench

//  Reads the 32-bit tag-list RAM written by the tag generator, picks up the
//  ROM start address for a selected sequence, then steps through ROM words
//  and drives LEDR, one word per step_en pulse, until the end-of-sequence

---
 rtl/seq_player.sv | 155 +++++++++++++++
 tb/tb_seq_player.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_player.sv
// Sequence player: looks up a sequence's ROM start address in the tag RAM, then
// walks ROM words onto LEDR, one word per step_en, until the end-of-sequence marker.
//
// state   | meaning
// IDLE    | no playback; waiting for seq_load
// TAG_REQ | tag RAM address presented, waiting out read latency
// TAG_CHK | tag word valid: check valid bit, load ROM start address
// FETCH   | ROM address presented, waiting out read latency
// LATCH   | capture LED field and end marker from the ROM word
// HOLD    | word on display, waiting for step_en
module seq_player #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int TAG_AW = 7,
    parameter int SEQ_W  = 6,
    parameter int LED_W  = 10
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              step_en,
    input  logic              seq_load,
    input  logic [SEQ_W-1:0]  seq_sel,
    output logic [TAG_AW-1:0] tag_rdaddr,
    input  logic [31:0]       tag_data,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [LED_W-1:0]  LEDR,
    output logic              playing,
    output logic              seq_done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TAG_REQ = 3'd1,
        S_TAG_CHK = 3'd2,
        S_FETCH   = 3'd3,
        S_LATCH   = 3'd4,
        S_HOLD    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_AW-1:0]   tag_rdaddr_q, tag_rdaddr_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [LED_W-1:0]    ledr_q, ledr_d;
    logic                last_q, last_d;
    logic                seq_done_q, seq_done_d;
    logic                err_q, err_d;

    logic                tag_valid;
    logic                rom_is_last;
    logic                addr_at_top;
    logic                unused_bits;

    assign tag_valid   = tag_data[31];
    assign rom_is_last = (rom_data[1:0] == 2'b11);
    assign addr_at_top = (rom_addr_q == {ADDR_W{1'b1}});

    // Tag bits between the start address and the valid flag, and ROM bits
    // between the LED field and the marker, carry nothing for this block.
    assign unused_bits = ^{tag_data[30:ADDR_W], rom_data[DATA_W-LED_W-1:2]};

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            tag_rdaddr_q <= '0;
            rom_addr_q   <= '0;
            ledr_q       <= '0;
            last_q       <= 1'b0;
            seq_done_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tag_rdaddr_q <= tag_rdaddr_d;
            rom_addr_q   <= rom_addr_d;
            ledr_q       <= ledr_d;
            last_q       <= last_d;
            seq_done_q   <= seq_done_d;
            err_q        <= err_d;
        end
    end

    // seq_load restarts from any state and takes priority over step_en.
    always_comb begin
        state_d = state_q;
        if (seq_load) begin
            state_d = S_TAG_REQ;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_TAG_REQ: state_d = S_TAG_CHK;
                S_TAG_CHK: state_d = tag_valid ? S_FETCH : S_IDLE;
                S_FETCH:   state_d = S_LATCH;
                S_LATCH:   state_d = S_HOLD;
                S_HOLD: begin
                    if (step_en) begin
                        state_d = (last_q || addr_at_top) ? S_IDLE : S_FETCH;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        tag_rdaddr_d = tag_rdaddr_q;
        rom_addr_d   = rom_addr_q;
        ledr_d       = ledr_q;
        last_d       = last_q;
        seq_done_d   = 1'b0;
        err_d        = err_q;
        if (seq_load) begin
            tag_rdaddr_d = {{(TAG_AW-SEQ_W){1'b0}}, seq_sel};
            err_d        = 1'b0;
        end else begin
            case (state_q)
                S_TAG_CHK: begin
                    if (tag_valid) begin
                        rom_addr_d = tag_data[ADDR_W-1:0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_LATCH: begin
                    ledr_d = rom_data[DATA_W-1 -: LED_W];
                    last_d = rom_is_last;
                end
                S_HOLD: begin
                    if (step_en) begin
                        if (last_q) begin
                            seq_done_d = 1'b1;
                            ledr_d     = '0;
                        end else if (addr_at_top) begin
                            // Running off the top of the ROM is a fault, never a wrap.
                            err_d  = 1'b1;
                            ledr_d = '0;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tag_rdaddr = tag_rdaddr_q;
    assign rom_addr   = rom_addr_q;
    assign LEDR       = ledr_q;
    assign playing    = (state_q != S_IDLE);
    assign seq_done   = seq_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seq_player.sv
// Bench for seq_player: a timeline model of playback predicts every output change,
// and a negedge monitor matches each observed change against the predicted queue.
module tb_seq_player;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int TAG_AW = 7;
    localparam int SEQ_W  = 6;
    localparam int LED_W  = 10;

    logic              CLK_50   = 1'b0;
    logic              reset    = 1'b1;
    logic              step_en  = 1'b0;
    logic              seq_load = 1'b0;
    logic [SEQ_W-1:0]  seq_sel  = '0;
    logic [TAG_AW-1:0] tag_rdaddr;
    logic [31:0]       tag_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [LED_W-1:0]  LEDR;
    logic              playing;
    logic              seq_done;
    logic              err;

    seq_player #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_AW(TAG_AW), .SEQ_W(SEQ_W), .LED_W(LED_W)
    ) dut (
        .CLK_50(CLK_50), .reset(reset), .step_en(step_en), .seq_load(seq_load),
        .seq_sel(seq_sel), .tag_rdaddr(tag_rdaddr), .tag_data(tag_data),
        .rom_addr(rom_addr), .rom_data(rom_data), .LEDR(LEDR), .playing(playing),
        .seq_done(seq_done), .err(err)
    );

    always #10 CLK_50 = ~CLK_50;

    logic [31:0] tag_mem [0:127];
    logic [15:0] rom     [0:1023];

    always @(posedge CLK_50) begin
        tag_data <= tag_mem[tag_rdaddr];
        rom_data <= rom[rom_addr];
    end

    typedef struct {
        int          e;
        logic [29:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    // Playback model: current outputs plus actions scheduled for future edges.
    logic [6:0]  m_tag;
    logic [9:0]  m_rom;
    logic [9:0]  m_led;
    logic        m_play, m_done, m_err, m_last;
    int          p_addr_due, p_show_due, p_fault_due;
    logic [9:0]  p_addr_val;
    logic [29:0] m_prev;

    function automatic logic [29:0] pack(input logic [6:0] t, input logic [9:0] r,
                                         input logic [9:0] l, input logic p,
                                         input logic d, input logic e);
        return {t, r, l, p, d, e};
    endfunction

    function automatic logic [9:0] led_of(input int a);
        logic [15:0] w;
        w = rom[a];
        return w[15:6];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, expv, edge_n);
        end
    endtask

    task automatic model_reset();
        m_tag = '0; m_rom = '0; m_led = '0;
        m_play = 1'b0; m_done = 1'b0; m_err = 1'b0; m_last = 1'b0;
        p_addr_due = 0; p_show_due = 0; p_fault_due = 0; p_addr_val = '0;
        m_prev = '0;
    endtask

    task automatic model_edge(input logic ld, input logic [5:0] sel, input logic st);
        logic [31:0] tw;
        logic [29:0] cur;
        logic [15:0] w;
        exp_t        x;
        int          e;
        e      = edge_n;
        m_done = 1'b0;
        if (ld) begin
            m_tag  = {1'b0, sel};
            m_err  = 1'b0;
            m_play = 1'b1;
            tw     = tag_mem[{1'b0, sel}];
            p_addr_due = 0; p_show_due = 0; p_fault_due = 0;
            if (tw[31]) begin
                p_addr_due = e + 2;
                p_addr_val = tw[9:0];
                p_show_due = e + 4;
            end else begin
                p_fault_due = e + 2;
            end
        end else if (st && m_play && p_addr_due == 0 && p_show_due == 0 && p_fault_due == 0) begin
            if (m_last) begin
                m_done = 1'b1; m_led = '0; m_play = 1'b0;
            end else if (m_rom == 10'h3FF) begin
                m_err = 1'b1; m_led = '0; m_play = 1'b0;
            end else begin
                m_rom      = m_rom + 10'd1;
                p_show_due = e + 2;
            end
        end
        if (p_addr_due == e) begin
            m_rom = p_addr_val; p_addr_due = 0;
        end
        if (p_fault_due == e) begin
            m_err = 1'b1; m_play = 1'b0; p_fault_due = 0;
        end
        if (p_show_due == e) begin
            w          = rom[m_rom];
            m_led      = w[15:6];
            m_last     = (w[1:0] == 2'b11);
            p_show_due = 0;
        end
        cur = pack(m_tag, m_rom, m_led, m_play, m_done, m_err);
        if (cur != m_prev) begin
            x.e = e;
            x.v = cur;
            exp_q.push_back(x);
            m_prev = cur;
        end
    endtask

    task automatic clk_edge();
        @(posedge CLK_50);
        edge_n++;
    endtask

    task automatic tick(input logic ld, input logic [5:0] sel, input logic st);
        seq_load = ld;
        seq_sel  = sel;
        step_en  = st;
        clk_edge();
        model_edge(ld, sel, st);
        #1;
        seq_load = 1'b0;
        step_en  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, seq_sel, 1'b0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_tag_rdaddr"}, 32'(tag_rdaddr), 0);
        chk({nm, "_rom_addr"},   32'(rom_addr),   0);
        chk({nm, "_ledr"},       32'(LEDR),       0);
        chk({nm, "_playing"},    32'(playing),    0);
        chk({nm, "_seq_done"},   32'(seq_done),   0);
        chk({nm, "_err"},        32'(err),        0);
    endtask

    task automatic do_reset(input string nm);
        @(negedge CLK_50);
        #1 reset = 1'b1;
        #1 chk_all_zero(nm);
        clk_edge();
        clk_edge();
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Monitor: every change of the output tuple must be the next predicted event.
    initial begin
        logic [29:0] prev, cur;
        exp_t        x;
        prev = '0;
        forever begin
            @(negedge CLK_50);
            if (reset) begin
                prev = '0;
                exp_q.delete();
            end else begin
                cur = pack(tag_rdaddr, rom_addr, LEDR, playing, seq_done, err);
                while (exp_q.size() > 0 && exp_q[0].e < edge_n) begin
                    x = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_event: edge %0d wanted %0h, outputs %0h", x.e, x.v, cur);
                end
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_change: got %0h expected %0h (edge %0d)", cur, prev, edge_n);
                    end else begin
                        x = exp_q.pop_front();
                        chk("event_value", 32'(cur), 32'(x.v));
                        chk("event_edge", edge_n, x.e);
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        logic [9:0]  key;
        logic [9:0]  av;
        logic [1:0]  mk;
        logic [31:0] tw;

        key = 10'($urandom_range(0, 1023));
        for (int a = 0; a < 1024; a++) begin
            av = a[9:0];
            mk = ($urandom_range(0, 5) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            rom[a] = {av ^ key, 4'($urandom_range(0, 15)), mk};
        end
        for (int i = 0; i < 128; i++) begin
            tw = $urandom;
            tw[31] = ($urandom_range(0, 3) != 0);
            tag_mem[i] = tw;
        end
        tag_mem[3] = 32'h8000_0040;
        tag_mem[5] = {1'b0, 31'($urandom)};
        tag_mem[7] = 32'h8000_03FE;
        tag_mem[1] = 32'h8000_0100;
        tag_mem[2] = 32'h8000_0200;
        tag_mem[9] = 32'h8000_0300;
        for (int a = 16'h040; a <= 16'h041; a++) rom[a][1:0] = 2'($urandom_range(0, 2));
        rom[16'h042][1:0] = 2'b11;
        rom[16'h3FE][1:0] = 2'($urandom_range(0, 2));
        rom[16'h3FF][1:0] = 2'($urandom_range(0, 2));
        rom[16'h100][1:0] = 2'($urandom_range(0, 2));
        for (int a = 16'h300; a <= 16'h307; a++) rom[a][1:0] = 2'($urandom_range(0, 2));
        rom[16'h308][1:0] = 2'b11;

        model_reset();
        reset = 1'b1;
        clk_edge();
        clk_edge();
        #1 chk_all_zero("reset");
        reset = 1'b0;

        // T1: three-word sequence ending on its marker
        tick(1'b1, 6'd3, 1'b0);
        idle(3);
        chk("t1_ledr_pre", 32'(LEDR), 0);
        idle(1);
        chk("t1_ledr_w0", 32'(LEDR), 32'(led_of(16'h040)));
        chk("t1_playing", 32'(playing), 1);
        tick(1'b0, 6'd3, 1'b1);
        idle(2);
        chk("t1_ledr_w1", 32'(LEDR), 32'(led_of(16'h041)));
        tick(1'b0, 6'd3, 1'b1);
        idle(2);
        chk("t1_ledr_w2", 32'(LEDR), 32'(led_of(16'h042)));
        tick(1'b0, 6'd3, 1'b1);
        chk("t1_done", 32'(seq_done), 1);
        chk("t1_ledr_end", 32'(LEDR), 0);
        chk("t1_playing_end", 32'(playing), 0);
        idle(1);
        chk("t1_done_pulse", 32'(seq_done), 0);

        // T2: invalid tag
        tick(1'b1, 6'd5, 1'b0);
        idle(1);
        chk("t2_err_early", 32'(err), 0);
        idle(1);
        chk("t2_err", 32'(err), 1);
        chk("t2_playing", 32'(playing), 0);
        chk("t2_rom_addr", 32'(rom_addr), 32'h042);

        // T3: run off the top of the ROM
        tick(1'b1, 6'd7, 1'b0);
        chk("t3_err_clr", 32'(err), 0);
        idle(4);
        chk("t3_ledr_w0", 32'(LEDR), 32'(led_of(16'h3FE)));
        tick(1'b0, 6'd7, 1'b1);
        idle(2);
        chk("t3_ledr_w1", 32'(LEDR), 32'(led_of(16'h3FF)));
        tick(1'b0, 6'd7, 1'b1);
        chk("t3_err", 32'(err), 1);
        chk("t3_ledr", 32'(LEDR), 0);
        chk("t3_rom_addr", 32'(rom_addr), 32'h3FF);
        idle(2);
        chk("t3_rom_addr_hold", 32'(rom_addr), 32'h3FF);

        // T4: reload during HOLD with a simultaneous step
        tick(1'b1, 6'd1, 1'b0);
        idle(5);
        tick(1'b1, 6'd2, 1'b1);
        chk("t4_tag_rdaddr", 32'(tag_rdaddr), 2);
        idle(3);
        chk("t4_ledr_old", 32'(LEDR), 32'(led_of(16'h100)));
        idle(1);
        chk("t4_ledr_new", 32'(LEDR), 32'(led_of(16'h200)));
        chk("t4_rom_addr", 32'(rom_addr), 32'h200);

        // T5: reset mid-fetch, then steps while idle
        tick(1'b1, 6'd3, 1'b0);
        idle(2);
        chk("t5_playing", 32'(playing), 1);
        chk("t5_rom_addr", 32'(rom_addr), 32'h040);
        do_reset("t5_reset");
        for (int i = 0; i < 5; i++) tick(1'b0, 6'd3, 1'b1);
        chk("t5_idle_ledr", 32'(LEDR), 0);
        chk("t5_idle_playing", 32'(playing), 0);

        // T6: step_en held high through a nine-word sequence
        tick(1'b1, 6'd9, 1'b1);
        for (int i = 0; i < 40; i++) tick(1'b0, 6'd9, 1'b1);
        chk("t6_playing", 32'(playing), 0);
        chk("t6_ledr", 32'(LEDR), 0);
        chk("t6_rom_addr", 32'(rom_addr), 32'h308);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 799) == 0) begin
                do_reset("rand_reset");
            end else begin
                tick(($urandom_range(0, 29) == 0), 6'($urandom_range(0, 63)),
                     1'($urandom_range(0, 1)));
            end
        end

        idle(10);
        @(negedge CLK_50);
        #1 chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
